// File: rtl/vga_timing_gen_pkg.sv
// rtl/vga_timing_gen_pkg.sv - shared phase type, default 1280x1024 timing and total helper
package vga_timing_pkg;

    typedef enum logic [1:0] {
        DISP  = 2'd0,
        FRONT = 2'd1,
        SYNC  = 2'd2,
        BACK  = 2'd3
    } vga_phase_t;

    localparam int DEF_H_DISP  = 1280;
    localparam int DEF_H_FRONT = 48;
    localparam int DEF_H_SYNC  = 112;
    localparam int DEF_H_BACK  = 248;
    localparam int DEF_V_DISP  = 1024;
    localparam int DEF_V_FRONT = 1;
    localparam int DEF_V_SYNC  = 3;
    localparam int DEF_V_BACK  = 38;

    function automatic int vga_total(input int disp, input int front, input int sync, input int back);
        return disp + front + sync + back;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster timing output bundle from generator to pixel pipeline
interface vga_timing_gen_if #(
    parameter int CW = 12
);
    logic          o_hsync;
    logic          o_vsync;
    logic          o_disp;
    logic [CW-1:0] o_x;
    logic [CW-1:0] o_y;
    logic          o_line_start;
    logic          o_frame_start;

    modport master (
        output o_hsync, o_vsync, o_disp, o_x, o_y, o_line_start, o_frame_start
    );

    modport slave (
        input  o_hsync, o_vsync, o_disp, o_x, o_y, o_line_start, o_frame_start
    );
endinterface

// File: rtl/vga_timing_gen_axis_timer.sv
// rtl/vga_timing_gen_axis_timer.sv - one raster axis: wrapping counter with DISP/FRONT/SYNC/BACK decode
module vga_axis_timer #(
    parameter int CW    = 12,
    parameter int DISP  = 1280,
    parameter int FRONT = 48,
    parameter int SYNC  = 112,
    parameter int BACK  = 248
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        adv,
    output logic [CW-1:0]               count,
    output vga_timing_pkg::vga_phase_t  phase,
    output logic                        wrap
);
    localparam int TOTAL = vga_timing_pkg::vga_total(DISP, FRONT, SYNC, BACK);
    localparam logic [CW-1:0] LAST        = CW'(TOTAL - 1);
    localparam logic [CW-1:0] FRONT_START = CW'(DISP);
    localparam logic [CW-1:0] SYNC_START  = CW'(DISP + FRONT);
    localparam logic [CW-1:0] BACK_START  = CW'(DISP + FRONT + SYNC);

    if (DISP < 1 || FRONT < 1 || SYNC < 1 || BACK < 1) begin : g_bad_phase
        $error("vga_axis_timer: every phase length must be at least 1");
    end
    if (TOTAL > (1 << CW)) begin : g_bad_total
        $error("vga_axis_timer: axis total does not fit in CW bits");
    end

    assign wrap = adv && (count == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (adv) begin
            count <= wrap ? '0 : count + CW'(1);
        end
    end

    always_comb begin
        phase = vga_timing_pkg::DISP;
        if (count >= BACK_START) begin
            phase = vga_timing_pkg::BACK;
        end else if (count >= SYNC_START) begin
            phase = vga_timing_pkg::SYNC;
        end else if (count >= FRONT_START) begin
            phase = vga_timing_pkg::FRONT;
        end
    end
endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - two-axis raster timing generator; registers axis decode into aligned outputs
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CW      = 12,
    parameter int H_DISP  = DEF_H_DISP,
    parameter int H_FRONT = DEF_H_FRONT,
    parameter int H_SYNC  = DEF_H_SYNC,
    parameter int H_BACK  = DEF_H_BACK,
    parameter int V_DISP  = DEF_V_DISP,
    parameter int V_FRONT = DEF_V_FRONT,
    parameter int V_SYNC  = DEF_V_SYNC,
    parameter int V_BACK  = DEF_V_BACK,
    parameter bit H_POL   = 1'b0,
    parameter bit V_POL   = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_ce,
    vga_timing_gen_if.master  vga
);
    logic [CW-1:0] h_count;
    logic [CW-1:0] v_count;
    vga_phase_t    h_phase;
    vga_phase_t    v_phase;
    logic          h_wrap;
    logic          v_wrap;

    vga_axis_timer #(
        .CW(CW), .DISP(H_DISP), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK)
    ) u_h_axis (
        .clk(clk), .rst(rst), .adv(i_ce),
        .count(h_count), .phase(h_phase), .wrap(h_wrap)
    );

    vga_axis_timer #(
        .CW(CW), .DISP(V_DISP), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK)
    ) u_v_axis (
        .clk(clk), .rst(rst), .adv(h_wrap),
        .count(v_count), .phase(v_phase), .wrap(v_wrap)
    );

    // A frame wrap can only ever happen on a line wrap.
    assert property (@(posedge clk) disable iff (rst) v_wrap |-> h_wrap);

    // Outputs describe the counter value held during the enabled cycle, so all stay mutually aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            vga.o_hsync       <= ~H_POL;
            vga.o_vsync       <= ~V_POL;
            vga.o_disp        <= 1'b0;
            vga.o_x           <= '0;
            vga.o_y           <= '0;
            vga.o_line_start  <= 1'b0;
            vga.o_frame_start <= 1'b0;
        end else if (i_ce) begin
            vga.o_hsync       <= (h_phase == SYNC) ? H_POL : ~H_POL;
            vga.o_vsync       <= (v_phase == SYNC) ? V_POL : ~V_POL;
            vga.o_disp        <= (h_phase == DISP) && (v_phase == DISP);
            vga.o_x           <= h_count;
            vga.o_y           <= v_count;
            vga.o_line_start  <= (h_count == '0);
            vga.o_frame_start <= (h_count == '0) && (v_count == '0);
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen on an 8x6 raster, two polarities
module tb_vga_timing_gen;
    localparam int HD = 4, HF = 1, HS = 2, HB = 1;
    localparam int VD = 3, VF = 1, VS = 1, VB = 1;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;
    localparam int FT = HT * VT;

    typedef struct packed {
        logic        hsync;
        logic        vsync;
        logic        disp;
        logic        ls;
        logic        fs;
        logic [11:0] x;
        logic [11:0] y;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ce  = 1'b0;

    always #5 clk = ~clk;

    vga_timing_gen_if #(.CW(12)) vif0 ();
    vga_timing_gen_if #(.CW(12)) vif1 ();

    vga_timing_gen #(
        .CW(12), .H_DISP(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISP(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .H_POL(1'b0), .V_POL(1'b0)
    ) dut0 (.clk(clk), .rst(rst), .i_ce(ce), .vga(vif0));

    vga_timing_gen #(
        .CW(12), .H_DISP(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISP(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .H_POL(1'b1), .V_POL(1'b0)
    ) dut1 (.clk(clk), .rst(rst), .i_ce(ce), .vga(vif1));

    int   n_checks = 0;
    int   n_fail   = 0;
    obs_t q0[$];
    obs_t q1[$];
    obs_t last0, last1;
    int   model_n = 0;
    int   exp_period = 0;
    int   epoch = 0;

    function automatic obs_t rst_obs(input bit hp, input bit vp);
        obs_t o;
        o = '0;
        o.hsync = ~hp;
        o.vsync = ~vp;
        return o;
    endfunction

    // Reference: position p enabled pixels into the frame, raster order.
    function automatic obs_t pos_obs(input int p, input bit hp, input bit vp);
        obs_t o;
        int x, y;
        x = p % HT;
        y = p / HT;
        o.x     = 12'(x);
        o.y     = 12'(y);
        o.disp  = (x < HD) && (y < VD);
        o.hsync = (x >= HD + HF && x < HD + HF + HS) ? hp : ~hp;
        o.vsync = (y >= VD + VF && y < VD + VF + VS) ? vp : ~vp;
        o.ls    = (x == 0);
        o.fs    = (p == 0);
        return o;
    endfunction

    task automatic step(input bit r, input bit c);
        obs_t e0, e1;
        @(negedge clk);
        rst = r;
        ce  = c;
        if (r) begin
            model_n = 0;
            e0 = rst_obs(1'b0, 1'b0);
            e1 = rst_obs(1'b1, 1'b0);
        end else if (c) begin
            e0 = pos_obs(model_n, 1'b0, 1'b0);
            e1 = pos_obs(model_n, 1'b1, 1'b0);
            model_n = (model_n + 1) % FT;
        end else begin
            e0 = last0;
            e1 = last1;
        end
        last0 = e0;
        last1 = e1;
        q0.push_back(e0);
        q1.push_back(e1);
    endtask

    task automatic check(input string name, input obs_t a, input obs_t e);
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s t=%0t: got hs=%b vs=%b de=%b ls=%b fs=%b x=%0d y=%0d, required hs=%b vs=%b de=%b ls=%b fs=%b x=%0d y=%0d",
                     name, $time, a.hsync, a.vsync, a.disp, a.ls, a.fs, a.x, a.y,
                     e.hsync, e.vsync, e.disp, e.ls, e.fs, e.x, e.y);
        end
    endtask

    // Monitor: one expected entry per clock edge, plus frame-period measurement on dut0.
    initial begin
        obs_t a0, a1, e0, e1;
        int   cyc = 0;
        int   last_rise = -1;
        int   seen_epoch = 0;
        logic fs_prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                e0 = q0.pop_front();
                e1 = q1.pop_front();
                a0 = {vif0.o_hsync, vif0.o_vsync, vif0.o_disp, vif0.o_line_start, vif0.o_frame_start, vif0.o_x, vif0.o_y};
                a1 = {vif1.o_hsync, vif1.o_vsync, vif1.o_disp, vif1.o_line_start, vif1.o_frame_start, vif1.o_x, vif1.o_y};
                check("pol00", a0, e0);
                check("pol10", a1, e1);
            end
            if (epoch != seen_epoch) begin
                seen_epoch = epoch;
                last_rise  = -1;
            end
            if (vif0.o_frame_start === 1'b1 && fs_prev !== 1'b1) begin
                if (exp_period != 0 && last_rise >= 0) begin
                    n_checks++;
                    if (cyc - last_rise != exp_period) begin
                        n_fail++;
                        $display("FAIL frame_period: got %0d clocks, required %0d", cyc - last_rise, exp_period);
                    end
                end
                last_rise = cyc;
            end
            fs_prev = vif0.o_frame_start;
            cyc++;
        end
    end

    initial begin
        int guard;
        repeat (3) step(1'b1, 1'b1);

        epoch++; exp_period = FT;
        for (int i = 0; i < 2 * FT + 10; i++) step(1'b0, 1'b1);

        epoch++; exp_period = 3 * FT;
        for (int i = 0; i < 450; i++) step(1'b0, (i % 3) == 0);

        epoch++; exp_period = 0;
        step(1'b1, 1'b0);
        for (int i = 0; i < 4 * HT + 5; i++) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1);

        for (int i = 0; i < 1500; i++) step($urandom_range(0, 59) == 0, $urandom_range(0, 1) == 1);

        guard = 0;
        while (q0.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        #2;
        n_checks++;
        if (q0.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending entries, required 0", q0.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
